// File: rtl/coffee_order_ctrl.sv
// coffee_order_ctrl: payment/order front-end for the coffee brewer.
// Collects coin credit, checks a drink selection against its price, then
// launches the brewer with a one-cycle start pulse and refunds leftover credit
// once the brewer reports done.
// Optional build macro: COIN_TIMEOUT_EN refunds credit automatically after
// TIMEOUT_CYC quiet cycles in COLLECT. When the macro is undefined, COLLECT
// waits indefinitely.
//
// Interface: coin_valid, sel_valid, cancel and brew_done are single-cycle
// strobes with no ready/backpressure. An input is acted on only in the cycle
// it is high. brew_start, change_valid, coin_reject and err_insufficient are
// single-cycle registered pulses. There is no acknowledge from the receiver.
module coffee_order_ctrl #(
    parameter int CREDIT_W         = 6,
    parameter int PRICE_ESPRESSO   = 10,
    parameter int PRICE_AMERICANO  = 12,
    parameter int PRICE_LATTE      = 15,
    parameter int PRICE_CAPPUCCINO = 18,
    parameter int TIMEOUT_CYC      = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [3:0]          coin_value,
    input  logic                sel_valid,
    input  logic [1:0]          sel_code,
    input  logic                cancel,
    input  logic                brew_done,
    output logic                brew_start,
    output logic [1:0]          brew_sel,
    output logic [CREDIT_W-1:0] credit,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                coin_reject,
    output logic                err_insufficient,
    output logic                busy,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_START   = 3'd2,
        S_BREW    = 3'd3,
        S_CHANGE  = 3'd4
    } state_t;

    // A zero or negative timeout has no meaningful behaviour.
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("coffee_order_ctrl: TIMEOUT_CYC must be at least 1");
    end

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [CREDIT_W-1:0]   change_amt_q, change_amt_d;
    logic [1:0]            brew_sel_q, brew_sel_d;
    logic                  brew_start_q, brew_start_d;
    logic                  change_valid_q, change_valid_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  err_insuf_q, err_insuf_d;
    logic                  busy_q, busy_d;

    // One extra bit so an overflowing coin is visible instead of wrapping.
    logic [CREDIT_W:0]     coin_sum;
    logic [CREDIT_W-1:0]   sel_price;
    logic                  timeout_hit;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] code);
        case (code)
            2'b00:   return CREDIT_W'(PRICE_ESPRESSO);
            2'b01:   return CREDIT_W'(PRICE_AMERICANO);
            2'b10:   return CREDIT_W'(PRICE_LATTE);
            default: return CREDIT_W'(PRICE_CAPPUCCINO);
        endcase
    endfunction

    assign coin_sum  = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value);
    assign sel_price = price_of(sel_code);

`ifdef COIN_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMR_W-1:0] tmr_q;

    assign timeout_hit = (state_q == S_COLLECT) && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

    // Quiet-cycle counter: only advances in COLLECT with no customer event;
    // it sits at zero outside COLLECT so entry always starts from zero.
    always_ff @(posedge clk) begin
        if (reset || state_q != S_COLLECT || coin_valid || sel_valid || cancel || timeout_hit) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            change_amt_q   <= '0;
            brew_sel_q     <= 2'b00;
            brew_start_q   <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            err_insuf_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_amt_q   <= change_amt_d;
            brew_sel_q     <= brew_sel_d;
            brew_start_q   <= brew_start_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            err_insuf_q    <= err_insuf_d;
            busy_q         <= busy_d;
        end
    end

    // Next-state and next-output decode. In COLLECT only the highest
    // priority event (cancel, then coin, then sel) is acted on.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_amt_d   = change_amt_q;
        brew_sel_d     = brew_sel_q;
        brew_start_d   = 1'b0;
        change_valid_d = 1'b0;
        coin_reject_d  = 1'b0;
        err_insuf_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (coin_valid) begin
                    credit_d = CREDIT_W'(coin_value);
                    state_d  = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (cancel) begin
                    change_amt_d   = credit_q;
                    change_valid_d = 1'b1;
                    coin_reject_d  = coin_valid;
                    state_d        = S_CHANGE;
                end else if (coin_valid) begin
                    if (!coin_sum[CREDIT_W]) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (sel_valid) begin
                    if (credit_q >= sel_price) begin
                        brew_sel_d   = sel_code;
                        credit_d     = credit_q - sel_price;
                        brew_start_d = 1'b1;
                        state_d      = S_START;
                    end else begin
                        err_insuf_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    change_amt_d   = credit_q;
                    change_valid_d = 1'b1;
                    state_d        = S_CHANGE;
                end
            end

            S_START: begin
                coin_reject_d = coin_valid;
                state_d       = S_BREW;
            end

            S_BREW: begin
                coin_reject_d = coin_valid;
                if (brew_done) begin
                    if (credit_q != '0) begin
                        change_amt_d   = credit_q;
                        change_valid_d = 1'b1;
                        state_d        = S_CHANGE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_CHANGE: begin
                coin_reject_d = coin_valid;
                credit_d      = '0;
                state_d       = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_START) || (state_d == S_BREW);
    end

    assign state            = state_q;
    assign credit           = credit_q;
    assign change_amt       = change_amt_q;
    assign brew_sel         = brew_sel_q;
    assign brew_start       = brew_start_q;
    assign change_valid     = change_valid_q;
    assign coin_reject      = coin_reject_q;
    assign err_insufficient = err_insuf_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_coffee_order_ctrl.sv
// Self-checking bench for coffee_order_ctrl. Directed scenarios plus randomized
// orders checked against an order-level model (credit arithmetic, price table,
// refund queue). Build with +define+COIN_TIMEOUT_EN to exercise auto-refund.
module tb_coffee_order_ctrl;
    localparam int CW  = 6;
    localparam int MAX = 63;
    localparam int TO  = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          coin_valid;
    logic [3:0]    coin_value;
    logic          sel_valid;
    logic [1:0]    sel_code;
    logic          cancel;
    logic          brew_done;
    logic          brew_start;
    logic [1:0]    brew_sel;
    logic [CW-1:0] credit;
    logic          change_valid;
    logic [CW-1:0] change_amt;
    logic          coin_reject;
    logic          err_insufficient;
    logic          busy;
    logic [2:0]    state;

    int checks   = 0;
    int failures = 0;
    logic [CW-1:0] exp_q[$];

    coffee_order_ctrl #(
        .CREDIT_W(CW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .coin_valid(coin_valid),
        .coin_value(coin_value),
        .sel_valid(sel_valid),
        .sel_code(sel_code),
        .cancel(cancel),
        .brew_done(brew_done),
        .brew_start(brew_start),
        .brew_sel(brew_sel),
        .credit(credit),
        .change_valid(change_valid),
        .change_amt(change_amt),
        .coin_reject(coin_reject),
        .err_insufficient(err_insufficient),
        .busy(busy),
        .state(state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        coin_valid = 1'b0; coin_value = 4'd0; sel_valid = 1'b0; sel_code = 2'b00;
        cancel = 1'b0; brew_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; idle_inputs(); cyc(); cyc(); reset = 1'b0;
    endtask

    task automatic drive_coin(input int v);
        coin_valid = 1'b1; coin_value = 4'(v); cyc(); coin_valid = 1'b0;
    endtask

    task automatic drive_sel(input int c);
        sel_valid = 1'b1; sel_code = 2'(c); cyc(); sel_valid = 1'b0;
    endtask

    task automatic drive_cancel();
        cancel = 1'b1; cyc(); cancel = 1'b0;
    endtask

    task automatic drive_done();
        brew_done = 1'b1; cyc(); brew_done = 1'b0;
    endtask

    function automatic int price_of(input int c);
        case (c)
            0: return 10;
            1: return 12;
            2: return 15;
            default: return 18;
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [21:0] obs;
        do_reset();
        obs = {state, credit, brew_start, brew_sel, change_valid, change_amt,
               coin_reject, err_insufficient, busy};
        checks++; if (obs !== 22'd0) begin failures++; $display("FAIL reset_outputs got=%h want=0", obs); end
    endtask

    task automatic test_idle_ignores();
        sel_valid = 1'b1; sel_code = 2'b00; cancel = 1'b1; brew_done = 1'b1; cyc(); idle_inputs();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL idle_ignore_state got=%0d want=0", state); end
        checks++; if ({err_insufficient, change_valid, brew_start, coin_reject} !== 4'b0) begin
            failures++; $display("FAIL idle_ignore_pulses got=%b want=0000", {err_insufficient, change_valid, brew_start, coin_reject});
        end
    endtask

    task automatic test_exact_price();
        drive_coin(10);
        checks++; if (state !== 3'd1 || credit !== 6'd10) begin failures++; $display("FAIL exact_first_coin state=%0d credit=%0d want 1/10", state, credit); end
        drive_coin(5);
        checks++; if (credit !== 6'd15) begin failures++; $display("FAIL exact_credit got=%0d want=15", credit); end
        drive_sel(2);
        checks++; if (brew_start !== 1'b1 || brew_sel !== 2'b10 || state !== 3'd2) begin
            failures++; $display("FAIL exact_start start=%b sel=%0d state=%0d want 1/2/2", brew_start, brew_sel, state);
        end
        checks++; if (credit !== 6'd0 || busy !== 1'b1) begin failures++; $display("FAIL exact_credit_busy credit=%0d busy=%b want 0/1", credit, busy); end
        cyc();
        checks++; if (brew_start !== 1'b0 || state !== 3'd3 || busy !== 1'b1) begin
            failures++; $display("FAIL exact_brew start=%b state=%0d busy=%b want 0/3/1", brew_start, state, busy);
        end
        repeat (3) cyc();
        drive_done();
        checks++; if (state !== 3'd0 || change_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL exact_done state=%0d cv=%b busy=%b want 0/0/0", state, change_valid, busy);
        end
    endtask

    task automatic test_change();
        drive_coin(10); drive_coin(10); drive_sel(0);
        checks++; if (credit !== 6'd10 || brew_sel !== 2'b00) begin failures++; $display("FAIL change_credit got=%0d sel=%0d want 10/0", credit, brew_sel); end
        cyc(); cyc();
        drive_done();
        checks++; if (change_valid !== 1'b1 || change_amt !== 6'd10 || state !== 3'd4) begin
            failures++; $display("FAIL change_pulse cv=%b amt=%0d state=%0d want 1/10/4", change_valid, change_amt, state);
        end
        cyc();
        checks++; if (change_valid !== 1'b0 || credit !== 6'd0 || state !== 3'd0 || change_amt !== 6'd10) begin
            failures++; $display("FAIL change_after cv=%b credit=%0d state=%0d amt=%0d want 0/0/0/10", change_valid, credit, state, change_amt);
        end
    endtask

    task automatic test_insufficient();
        drive_coin(10); drive_sel(2);
        checks++; if (err_insufficient !== 1'b1 || credit !== 6'd10 || state !== 3'd1) begin
            failures++; $display("FAIL insuf_pulse err=%b credit=%0d state=%0d want 1/10/1", err_insufficient, credit, state);
        end
        cyc();
        checks++; if (err_insufficient !== 1'b0) begin failures++; $display("FAIL insuf_one_cycle got=%b want=0", err_insufficient); end
        drive_cancel();
        checks++; if (change_valid !== 1'b1 || change_amt !== 6'd10) begin
            failures++; $display("FAIL insuf_refund cv=%b amt=%0d want 1/10", change_valid, change_amt);
        end
        cyc();
    endtask

    task automatic test_overflow();
        repeat (4) drive_coin(15);
        checks++; if (credit !== 6'd60) begin failures++; $display("FAIL ovf_credit got=%0d want=60", credit); end
        drive_coin(5);
        checks++; if (coin_reject !== 1'b1 || credit !== 6'd60) begin failures++; $display("FAIL ovf_reject rej=%b credit=%0d want 1/60", coin_reject, credit); end
        cyc();
        checks++; if (coin_reject !== 1'b0) begin failures++; $display("FAIL ovf_reject_pulse got=%b want=0", coin_reject); end
        cancel = 1'b1; drive_coin(4); cancel = 1'b0;
        checks++; if (change_valid !== 1'b1 || change_amt !== 6'd60 || coin_reject !== 1'b1) begin
            failures++; $display("FAIL ovf_cancel_coin cv=%b amt=%0d rej=%b want 1/60/1", change_valid, change_amt, coin_reject);
        end
        cyc();
        repeat (4) drive_coin(15);
        drive_coin(3);
        checks++; if (credit !== 6'd63 || coin_reject !== 1'b0) begin failures++; $display("FAIL max_accept credit=%0d rej=%b want 63/0", credit, coin_reject); end
        drive_coin(0);
        checks++; if (credit !== 6'd63 || coin_reject !== 1'b0) begin failures++; $display("FAIL max_zero_coin credit=%0d rej=%b want 63/0", credit, coin_reject); end
        drive_coin(1);
        checks++; if (credit !== 6'd63 || coin_reject !== 1'b1) begin failures++; $display("FAIL max_reject credit=%0d rej=%b want 63/1", credit, coin_reject); end
        drive_cancel();
        checks++; if (change_amt !== 6'd63 || change_valid !== 1'b1) begin failures++; $display("FAIL max_refund amt=%0d cv=%b want 63/1", change_amt, change_valid); end
        cyc();
    endtask

`ifdef COIN_TIMEOUT_EN
    task automatic test_timeout();
        drive_coin(7);
        for (int i = 0; i < TO - 1; i++) begin
            checks++; if (state !== 3'd1) begin failures++; $display("FAIL timeout_early cycle=%0d state=%0d want=1", i, state); end
            cyc();
        end
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL timeout_last state=%0d want=1", state); end
        cyc();
        checks++; if (state !== 3'd4 || change_valid !== 1'b1 || change_amt !== 6'd7) begin
            failures++; $display("FAIL timeout_refund state=%0d cv=%b amt=%0d want 4/1/7", state, change_valid, change_amt);
        end
        cyc();
        drive_coin(7);
        repeat (15) cyc();
        drive_coin(1);
        repeat (TO - 1) cyc();
        checks++; if (state !== 3'd1 || credit !== 6'd8) begin failures++; $display("FAIL timeout_restart state=%0d credit=%0d want 1/8", state, credit); end
        cyc();
        checks++; if (change_valid !== 1'b1 || change_amt !== 6'd8) begin failures++; $display("FAIL timeout_restart_refund cv=%b amt=%0d want 1/8", change_valid, change_amt); end
        cyc();
    endtask
`else
    task automatic test_no_timeout();
        drive_coin(7);
        repeat (300) cyc();
        checks++; if (state !== 3'd1 || credit !== 6'd7 || change_valid !== 1'b0) begin
            failures++; $display("FAIL no_timeout state=%0d credit=%0d cv=%b want 1/7/0", state, credit, change_valid);
        end
        drive_cancel();
        checks++; if (change_valid !== 1'b1 || change_amt !== 6'd7) begin failures++; $display("FAIL no_timeout_refund cv=%b amt=%0d want 1/7", change_valid, change_amt); end
        cyc();
    endtask
`endif

    task automatic test_random();
        int ncoin, v, code, pr, mcredit, gap, delay;
        logic exp_rej, cv_bit;
        logic [1:0] last_sel;
        logic [CW-1:0] want;
        do_reset();
        last_sel = 2'b00;
        for (int t = 0; t < 40; t++) begin
            ncoin   = $urandom_range(1, 7);
            mcredit = 0;
            for (int k = 0; k < ncoin; k++) begin
                v   = $urandom_range(0, 15);
                gap = $urandom_range(0, 2);
                repeat (gap) cyc();
                brew_done = 1'($urandom_range(0, 1));
                drive_coin(v);
                brew_done = 1'b0;
                if (k == 0 || mcredit + v <= MAX) begin
                    mcredit = mcredit + v; exp_rej = 1'b0;
                end else begin
                    exp_rej = 1'b1;
                end
                checks++; if (coin_reject !== exp_rej || credit !== CW'(mcredit)) begin
                    failures++; $display("FAIL rand_coin order=%0d rej=%b credit=%0d want %b/%0d", t, coin_reject, credit, exp_rej, mcredit);
                end
            end
            code = $urandom_range(0, 3);
            pr   = price_of(code);
            drive_sel(code);
            if (mcredit >= pr) begin
                mcredit  = mcredit - pr;
                last_sel = 2'(code);
                checks++; if (brew_start !== 1'b1 || brew_sel !== last_sel || credit !== CW'(mcredit) || busy !== 1'b1) begin
                    failures++; $display("FAIL rand_start order=%0d start=%b sel=%0d credit=%0d busy=%b want 1/%0d/%0d/1",
                                         t, brew_start, brew_sel, credit, busy, last_sel, mcredit);
                end
                cyc();
                delay = $urandom_range(0, 4);
                for (int d = 0; d < delay; d++) begin
                    cv_bit = 1'($urandom_range(0, 1));
                    coin_valid = cv_bit; coin_value = 4'($urandom_range(0, 15));
                    sel_valid = 1'($urandom_range(0, 1)); cancel = 1'($urandom_range(0, 1));
                    cyc();
                    idle_inputs();
                    checks++; if (coin_reject !== cv_bit || state !== 3'd3 || credit !== CW'(mcredit) || brew_start !== 1'b0) begin
                        failures++; $display("FAIL rand_brew order=%0d rej=%b state=%0d credit=%0d start=%b want %b/3/%0d/0",
                                             t, coin_reject, state, credit, brew_start, cv_bit, mcredit);
                    end
                end
                drive_done();
                if (mcredit > 0) exp_q.push_back(CW'(mcredit));
            end else begin
                checks++; if (err_insufficient !== 1'b1 || credit !== CW'(mcredit) || state !== 3'd1 || brew_sel !== last_sel) begin
                    failures++; $display("FAIL rand_insuf order=%0d err=%b credit=%0d state=%0d sel=%0d want 1/%0d/1/%0d",
                                         t, err_insufficient, credit, state, brew_sel, mcredit, last_sel);
                end
                exp_q.push_back(CW'(mcredit));
                drive_cancel();
            end
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++; if (change_valid !== 1'b1 || change_amt !== want) begin
                    failures++; $display("FAIL rand_change order=%0d cv=%b amt=%0d want 1/%0d", t, change_valid, change_amt, want);
                end
                cyc();
            end else begin
                checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL rand_nochange order=%0d cv=%b want=0", t, change_valid); end
            end
            checks++; if (state !== 3'd0 || credit !== 6'd0 || busy !== 1'b0) begin
                failures++; $display("FAIL rand_end order=%0d state=%0d credit=%0d busy=%b want 0/0/0", t, state, credit, busy);
            end
        end
    endtask

    task automatic test_brew_inputs();
        logic [21:0] obs;
        drive_coin(15); drive_coin(5); drive_sel(3);
        checks++; if (credit !== 6'd2 || brew_sel !== 2'b11) begin failures++; $display("FAIL brewin_credit credit=%0d sel=%0d want 2/3", credit, brew_sel); end
        cyc();
        drive_coin(5);
        checks++; if (coin_reject !== 1'b1 || credit !== 6'd2 || brew_start !== 1'b0 || state !== 3'd3) begin
            failures++; $display("FAIL brewin_coin rej=%b credit=%0d start=%b state=%0d want 1/2/0/3", coin_reject, credit, brew_start, state);
        end
        drive_sel(0);
        checks++; if (state !== 3'd3 || brew_start !== 1'b0 || brew_sel !== 2'b11 || credit !== 6'd2) begin
            failures++; $display("FAIL brewin_sel state=%0d start=%b sel=%0d credit=%0d want 3/0/3/2", state, brew_start, brew_sel, credit);
        end
        drive_cancel();
        checks++; if (state !== 3'd3 || change_valid !== 1'b0) begin failures++; $display("FAIL brewin_cancel state=%0d cv=%b want 3/0", state, change_valid); end
        reset = 1'b1; cyc(); reset = 1'b0;
        obs = {state, credit, brew_start, brew_sel, change_valid, change_amt, coin_reject, err_insufficient, busy};
        checks++; if (obs !== 22'd0) begin failures++; $display("FAIL brewin_reset got=%h want=0", obs); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_idle_ignores();
        test_exact_price();
        test_change();
        test_insufficient();
        test_overflow();
`ifdef COIN_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        test_brew_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
